// File: rtl/mem_io_resp.sv
// Bus responder for the 8-bit CPU memory bus: 28 bytes of RAM, an output FIFO, STATUS/CTRL registers.
// Optional input port at 0x1E is compiled in when MEMIO_INPORT_EN is defined.
module mem_io_resp #(
  parameter int FIFO_DEPTH = 4,
  parameter int RAM_WORDS  = 28
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] addr,
  input  logic       rd,
  input  logic       wr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       rdata_oe,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready
`ifdef MEMIO_INPORT_EN
  ,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [4:0]    RAM_LAST = 5'(RAM_WORDS - 1);
  localparam logic [4:0]    A_OUT    = 5'h1C;
  localparam logic [4:0]    A_STAT   = 5'h1D;
  localparam logic [4:0]    A_IN     = 5'h1E;
  localparam logic [4:0]    A_CTRL   = 5'h1F;
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  logic [7:0]    ram_mem  [RAM_WORDS];
  logic [7:0]    fifo_mem [FIFO_DEPTH];

  logic          rd_q, wr_q;
  logic [7:0]    rdata_q, rdata_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          in_full;
  logic [7:0]    in_byte;

  logic          rd_rise, wr_rise;
  logic          pop, push_req, push, flush, ovf_clr;
  logic          fifo_full, fifo_empty;
  logic [3:0]    cnt_ext;
  logic [7:0]    status;
  logic [7:0]    rd_val;

  // A read strobe overlapping a write is illegal; the write wins and the read is ignored.
  assign rd_rise    = rd & ~rd_q & ~wr;
  assign wr_rise    = wr & ~wr_q;

  assign fifo_full  = (cnt_q == CNT_FULL);
  assign fifo_empty = (cnt_q == '0);
  assign out_valid  = ~fifo_empty;
  assign out_data   = fifo_mem[head_q];
  assign pop        = out_valid & out_ready;

  assign push_req   = wr_rise && (addr == A_OUT);
  assign push       = push_req & (~fifo_full | pop);
  assign flush      = wr_rise && (addr == A_CTRL) && wdata[0];
  assign ovf_clr    = wr_rise && (addr == A_CTRL) && wdata[7];

  assign cnt_ext    = 4'(cnt_q);
  assign status     = {ovf_q, in_full, fifo_full, fifo_empty, 1'b0, cnt_ext[2:0]};

  assign rdata      = rdata_q;
  assign rdata_oe   = rd_q & rd & ~wr;

  always_comb begin
    rd_val = 8'h00;
    if (addr <= RAM_LAST)
      rd_val = ram_mem[addr];
    else if (addr == A_STAT)
      rd_val = status;
    else if ((addr == A_IN) && in_full)
      rd_val = in_byte;
    rdata_d = rd_rise ? rd_val : rdata_q;
  end

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    if (ovf_clr)
      ovf_d = 1'b0;
    else if (push_req && !push)
      ovf_d = 1'b1;
    // Flush overrides any stream pop landing on the same edge.
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      if (pop)
        head_d = head_q + PW'(1);
      if (push)
        tail_d = tail_q + PW'(1);
      if (push && !pop)
        cnt_d = cnt_q + CW'(1);
      else if (pop && !push)
        cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    // Edge registers track the live strobes even in reset, so a held strobe yields no rise.
    rd_q <= rd;
    wr_q <= wr;
    if (rst) begin
      rdata_q <= 8'h00;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr && (addr <= RAM_LAST))
      ram_mem[addr] <= wdata;
    if (!rst && push)
      fifo_mem[tail_q] <= wdata;
  end

`ifdef MEMIO_INPORT_EN
  logic       in_full_q, in_full_d;
  logic [7:0] in_byte_q, in_byte_d;
  logic       in_pop, in_cap;

  assign in_ready = ~in_full_q;
  assign in_cap   = in_valid & in_ready;
  assign in_pop   = rd_rise && (addr == A_IN) && in_full_q;
  assign in_full  = in_full_q;
  assign in_byte  = in_byte_q;

  always_comb begin
    in_full_d = in_cap | (in_full_q & ~in_pop);
    in_byte_d = in_cap ? in_data : in_byte_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_full_q <= 1'b0;
      in_byte_q <= 8'h00;
    end else begin
      in_full_q <= in_full_d;
      in_byte_q <= in_byte_d;
    end
  end
`else
  assign in_full = 1'b0;
  assign in_byte = 8'h00;
`endif

endmodule

// File: tb/tb_mem_io_resp.sv
// Directed bench for mem_io_resp with scoreboards for bus reads and the output stream.
module tb_mem_io_resp;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] addr;
  logic       rd, wr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       rdata_oe;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
`ifdef MEMIO_INPORT_EN
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
`endif

  int n_total = 0;
  int n_pass  = 0;
  logic [7:0] exp_q [$];
  logic [7:0] rd_sb [$];

  always #5 clk = ~clk;

  mem_io_resp #(.FIFO_DEPTH(4), .RAM_WORDS(28)) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .rd        (rd),
    .wr        (wr),
    .wdata     (wdata),
    .rdata     (rdata),
    .rdata_oe  (rdata_oe),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef MEMIO_INPORT_EN
    ,
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready)
`endif
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%02h expected=0x%02h", tag, obs, exp);
  endtask

  // Stream scoreboard: every handshake pops the oldest expected byte.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("stream_unexpected", out_data, 8'hxx);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("stream_data", out_data, e);
        $display("stream pop: data=0x%02h", out_data);
      end
    end
  end

  task automatic bus_write(input logic [4:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    addr = a; wdata = d; wr = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0;
    $display("write addr=0x%02h data=0x%02h", a, d);
  endtask

  task automatic bus_read(input logic [4:0] a, input logic [7:0] exp, input string tag, input int hold);
    logic [7:0] e;
    @(posedge clk); #1;
    addr = a; rd = 1'b1;
    rd_sb.push_back(exp);
    @(posedge clk); #1;
    e = rd_sb.pop_front();
    check(tag, rdata, e);
    check({tag, "_oe"}, {7'd0, rdata_oe}, 8'h01);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold"}, rdata, e);
    end
    rd = 1'b0;
    $display("read  addr=0x%02h data=0x%02h", a, rdata);
  endtask

  task automatic fifo_write(input logic [7:0] d, input bit accepted);
    if (accepted) exp_q.push_back(d);
    bus_write(5'h1C, d);
  endtask

  task automatic drain(input int cycles);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; addr = '0; rd = 1'b0; wr = 1'b0; wdata = '0; out_ready = 1'b0;
`ifdef MEMIO_INPORT_EN
    in_data = '0; in_valid = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_rdata", rdata, 8'h00);
    check("rst_oe", {7'd0, rdata_oe}, 8'h00);
    check("rst_out_valid", {7'd0, out_valid}, 8'h00);
    bus_read(5'h1D, 8'h10, "rst_status", 0);

    // RAM, including the last RAM byte and a held read
    bus_write(5'h03, 8'hA5);
    bus_write(5'h1B, 8'h5A);
    bus_read(5'h03, 8'hA5, "ram_03", 2);
    bus_read(5'h1B, 8'h5A, "ram_1b", 0);

    // FIFO fill beyond capacity
    fifo_write(8'h11, 1'b1);
    fifo_write(8'h22, 1'b1);
    fifo_write(8'h33, 1'b1);
    fifo_write(8'h44, 1'b1);
    fifo_write(8'h55, 1'b0);
    bus_read(5'h1D, 8'hA4, "fill_status", 0);
    check("fill_head", out_data, 8'h11);
    bus_read(5'h1C, 8'h00, "out_readback", 0);
    bus_read(5'h1F, 8'h00, "ctrl_readback", 0);
    bus_write(5'h1D, 8'hFF);
    bus_read(5'h1D, 8'hA4, "status_ro", 0);

    // Drain
    drain(4);
    check("drain_valid", {7'd0, out_valid}, 8'h00);
    bus_read(5'h1D, 8'h90, "drain_status", 0);
    bus_write(5'h1F, 8'h80);
    bus_read(5'h1D, 8'h10, "ovf_clear", 0);

    // Held write strobe yields one push
    @(posedge clk); #1;
    addr = 5'h1C; wdata = 8'h7E; wr = 1'b1;
    exp_q.push_back(8'h7E);
    repeat (3) @(posedge clk);
    #1 wr = 1'b0;
    bus_read(5'h1D, 8'h01, "held_wr_status", 0);
    drain(2);

    // Flush while a pop happens on the same edge
    fifo_write(8'h01, 1'b1);
    fifo_write(8'h02, 1'b1);
    @(posedge clk); #1;
    addr = 5'h1F; wdata = 8'h01; wr = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0;
    exp_q.delete();
    check("flush_valid", {7'd0, out_valid}, 8'h00);
    out_ready = 1'b0;
    bus_read(5'h1D, 8'h10, "flush_status", 0);

    // Push into a full FIFO while popping
    fifo_write(8'hA1, 1'b1);
    fifo_write(8'hA2, 1'b1);
    fifo_write(8'hA3, 1'b1);
    fifo_write(8'hA4, 1'b1);
    @(posedge clk); #1;
    addr = 5'h1C; wdata = 8'h99; wr = 1'b1; out_ready = 1'b1;
    exp_q.push_back(8'h99);
    @(posedge clk); #1;
    wr = 1'b0; out_ready = 1'b0;
    bus_read(5'h1D, 8'h24, "full_pop_status", 0);
    drain(4);
    bus_read(5'h1D, 8'h10, "full_pop_drained", 0);

    // Illegal simultaneous rd and wr: write wins, bus not driven
    @(posedge clk); #1;
    addr = 5'h05; wdata = 8'h3C; rd = 1'b1; wr = 1'b1;
    @(posedge clk); #1;
    check("rdwr_oe", {7'd0, rdata_oe}, 8'h00);
    rd = 1'b0; wr = 1'b0;
    bus_read(5'h05, 8'h3C, "rdwr_ram", 0);

    // Reset with a held write strobe: state clears and no push after release
    fifo_write(8'h10, 1'b1);
    check("pre_rst_valid", {7'd0, out_valid}, 8'h01);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1; addr = 5'h1C; wdata = 8'h42; wr = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 wr = 1'b0;
    check("rst_held_valid", {7'd0, out_valid}, 8'h00);
    bus_read(5'h1D, 8'h10, "rst_held_status", 0);

`ifdef MEMIO_INPORT_EN
    @(posedge clk); #1;
    in_data = 8'h3C; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("in_ready_full", {7'd0, in_ready}, 8'h00);
    bus_read(5'h1D, 8'h50, "in_status", 0);
    bus_read(5'h1E, 8'h3C, "in_read", 0);
    check("in_ready_free", {7'd0, in_ready}, 8'h01);
    bus_read(5'h1E, 8'h00, "in_read_empty", 0);
`else
    bus_read(5'h1E, 8'h00, "in_disabled", 0);
`endif

    check("stream_leftover", 8'(exp_q.size()), 8'h00);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
